// File: rtl/fixed_point_mult_seq_if.sv
// Operand/result handshake bundle for the sequential fixed-point multiplier.
interface fixed_point_mult_seq_if #(
    parameter int A_WIDTH = 16,
    parameter int B_WIDTH = 16,
    parameter int P_WIDTH = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [A_WIDTH-1:0] A;
    logic signed [B_WIDTH-1:0] B;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [P_WIDTH-1:0] P;
    logic                      overflow;
    logic                      busy;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, P, overflow, busy
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, P, overflow, busy
    );
endinterface

// File: rtl/fixed_point_mult_seq.sv
// Radix-2 shift-add signed fixed-point multiplier with round-half-away and saturation.
//   state  | meaning
//   IDLE   | waiting for operands, in_ready high
//   CALC   | one partial product per cycle, B_WIDTH cycles
//   FINISH | round, saturate and register the product
//   DONE   | result presented until out_ready
module fixed_point_mult_seq #(
    parameter int A_WIDTH     = 16,
    parameter int A_FRAC_BITS = 14,
    parameter int B_WIDTH     = 16,
    parameter int B_FRAC_BITS = 14,
    parameter int P_WIDTH     = 16,
    parameter int P_FRAC_BITS = 14
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    fixed_point_mult_seq_if.slave  bus
);
    localparam int S     = A_FRAC_BITS + B_FRAC_BITS - P_FRAC_BITS;
    localparam int ACC_W = A_WIDTH + B_WIDTH;
    localparam int RW    = ACC_W + 1;
    localparam int CNT_W = $clog2(B_WIDTH + 1);

    if (S < 1) begin : g_bad_frac
        $error("fixed_point_mult_seq: A_FRAC_BITS+B_FRAC_BITS-P_FRAC_BITS must be >= 1");
    end

    localparam logic [RW-1:0]      RND     = RW'(1) << (S - 1);
    localparam logic [RW-1:0]      POS_LIM = (RW'(1) << (P_WIDTH - 1)) - RW'(1);
    localparam logic [RW-1:0]      NEG_LIM = RW'(1) << (P_WIDTH - 1);
    localparam logic [P_WIDTH-1:0] P_MAX   = {1'b0, {(P_WIDTH-1){1'b1}}};
    localparam logic [P_WIDTH-1:0] P_MIN   = {1'b1, {(P_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FINISH, DONE} state_t;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] a_mag_q, a_mag_d;
    logic [B_WIDTH-1:0] b_mag_q, b_mag_d;
    logic               sign_q, sign_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [P_WIDTH-1:0] p_q, p_d;
    logic               ovf_q, ovf_d;
    logic [RW-1:0]      mag_r;

    // Rounding on the magnitude makes the result symmetric, i.e. half away from zero.
    assign mag_r = (RW'(acc_q) + RND) >> S;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            a_mag_q <= '0;
            b_mag_q <= '0;
            sign_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_mag_q <= a_mag_d;
            b_mag_q <= b_mag_d;
            sign_q  <= sign_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_mag_d = a_mag_q;
        b_mag_d = b_mag_q;
        sign_d  = sign_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_mag_d = bus.A[A_WIDTH-1] ? (~bus.A + A_WIDTH'(1)) : bus.A;
                    b_mag_d = bus.B[B_WIDTH-1] ? (~bus.B + B_WIDTH'(1)) : bus.B;
                    sign_d  = bus.A[A_WIDTH-1] ^ bus.B[B_WIDTH-1];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (b_mag_q[0]) begin
                    acc_d = acc_q + (ACC_W'(a_mag_q) << cnt_q);
                end
                b_mag_d = b_mag_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(B_WIDTH - 1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                if (!sign_q) begin
                    if (mag_r > POS_LIM) begin
                        p_d   = P_MAX;
                        ovf_d = 1'b1;
                    end else begin
                        p_d   = mag_r[P_WIDTH-1:0];
                        ovf_d = 1'b0;
                    end
                end else begin
                    if (mag_r > NEG_LIM) begin
                        p_d   = P_MIN;
                        ovf_d = 1'b1;
                    end else begin
                        // A zero magnitude negates to zero, so there is no -0 case.
                        p_d   = ~mag_r[P_WIDTH-1:0] + P_WIDTH'(1);
                        ovf_d = 1'b0;
                    end
                end
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.P         = p_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_fixed_point_mult_seq.sv
// Directed-vector bench for fixed_point_mult_seq at the default Q2.14 configuration.
module tb_fixed_point_mult_seq;
    logic clk_in = 1'b0;
    logic rst_in;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    fixed_point_mult_seq_if #(.A_WIDTH(16), .B_WIDTH(16), .P_WIDTH(16)) bus ();

    fixed_point_mult_seq #(
        .A_WIDTH(16), .A_FRAC_BITS(14),
        .B_WIDTH(16), .B_FRAC_BITS(14),
        .P_WIDTH(16), .P_FRAC_BITS(14)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
        logic        ovf;
    } vec_t;

    // Launch one operation; returns result and cycles from accepting edge to out_valid (-1 on timeout).
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit release_out,
                         output logic [15:0] p, output logic ovf, output int lat);
        int guard;
        @(negedge clk_in);
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk_in);
            guard++;
        end
        bus.A = a;
        bus.B = b;
        bus.in_valid = 1'b1;
        @(posedge clk_in);
        #1;
        bus.in_valid = 1'b0;
        bus.A = 16'h5A5A;
        bus.B = 16'h3C3C;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk_in);
            #1;
            lat++;
        end
        if (!bus.out_valid) lat = -1;
        p   = bus.P;
        ovf = bus.overflow;
        if (release_out) begin
            @(negedge clk_in);
            bus.out_ready = 1'b1;
            @(posedge clk_in);
            #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        #12;
        vec_cnt++;
        if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        vec_cnt++;
        if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        vec_cnt++;
        if (bus.P !== 16'h0000) begin err_cnt++; $display("FAIL reset_P got %h want 0000", bus.P); end
        vec_cnt++;
        if (bus.overflow !== 1'b0) begin err_cnt++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
        vec_cnt++;
        if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] p;
        logic        ovf;
        int          lat;
        do_op(16'h2000, 16'h2000, 1'b1, p, ovf, lat);
        vec_cnt++;
        if (p !== 16'h1000) begin err_cnt++; $display("FAIL basic_P got %h want 1000", p); end
        vec_cnt++;
        if (ovf !== 1'b0) begin err_cnt++; $display("FAIL basic_overflow got %b want 0", ovf); end
        vec_cnt++;
        if (lat !== 17) begin err_cnt++; $display("FAIL basic_latency got %0d want 17", lat); end
    endtask

    task automatic test_vectors();
        vec_t        vt [13];
        logic [15:0] p;
        logic        ovf;
        int          lat;
        vt = '{
            '{16'hA000, 16'h5000, 16'h8800, 1'b0},
            '{16'h8000, 16'h4000, 16'h8000, 1'b0},
            '{16'h6000, 16'h6000, 16'h7FFF, 1'b1},
            '{16'h8000, 16'h8000, 16'h7FFF, 1'b1},
            '{16'h8000, 16'h6000, 16'h8000, 1'b1},
            '{16'h0001, 16'h2000, 16'h0001, 1'b0},
            '{16'hFFFF, 16'h2000, 16'hFFFF, 1'b0},
            '{16'h0001, 16'h0001, 16'h0000, 1'b0},
            '{16'hFFFF, 16'h0001, 16'h0000, 1'b0},
            '{16'h0003, 16'h2000, 16'h0002, 1'b0},
            '{16'hFFFD, 16'h2000, 16'hFFFE, 1'b0},
            '{16'h4000, 16'hFFFF, 16'hFFFF, 1'b0},
            '{16'hC000, 16'hC000, 16'h4000, 1'b0}
        };
        for (int i = 0; i < 13; i++) begin
            do_op(vt[i].a, vt[i].b, 1'b1, p, ovf, lat);
            vec_cnt++;
            if (p !== vt[i].p) begin
                err_cnt++;
                $display("FAIL vec%0d_P a=%h b=%h got %h want %h", i, vt[i].a, vt[i].b, p, vt[i].p);
            end
            vec_cnt++;
            if (ovf !== vt[i].ovf) begin
                err_cnt++;
                $display("FAIL vec%0d_overflow a=%h b=%h got %b want %b", i, vt[i].a, vt[i].b, ovf, vt[i].ovf);
            end
            vec_cnt++;
            if (lat !== 17) begin err_cnt++; $display("FAIL vec%0d_latency got %0d want 17", i, lat); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] p;
        logic        ovf;
        int          lat;
        do_op(16'h2000, 16'hC000, 1'b0, p, ovf, lat);
        vec_cnt++;
        if (p !== 16'hE000) begin err_cnt++; $display("FAIL bp_P got %h want e000", p); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_in);
            #1;
            vec_cnt++;
            if ({bus.out_valid, bus.in_ready, bus.P, bus.overflow} !== {1'b1, 1'b0, 16'hE000, 1'b0}) begin
                err_cnt++;
                $display("FAIL bp_hold cyc=%0d got ov=%b ir=%b P=%h ovf=%b want ov=1 ir=0 P=e000 ovf=0",
                         i, bus.out_valid, bus.in_ready, bus.P, bus.overflow);
            end
        end
        @(negedge clk_in);
        bus.out_ready = 1'b1;
        @(posedge clk_in);
        #1;
        bus.out_ready = 1'b0;
        vec_cnt++;
        if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_release_out_valid got %b want 0", bus.out_valid); end
        vec_cnt++;
        if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_release_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_back_to_back();
        int pulses [3];
        int np;
        @(negedge clk_in);
        bus.A = 16'hA000;
        bus.B = 16'h5000;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        np = 0;
        for (int c = 1; c <= 70; c++) begin
            @(posedge clk_in);
            #1;
            if (bus.out_valid) begin
                if (np < 3) pulses[np] = c;
                np++;
                vec_cnt++;
                if (bus.P !== 16'h8800) begin err_cnt++; $display("FAIL b2b_P cyc=%0d got %h want 8800", c, bus.P); end
            end
        end
        @(negedge clk_in);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        vec_cnt++;
        if (np !== 3) begin
            err_cnt++;
            $display("FAIL b2b_pulse_count got %0d want 3", np);
        end else begin
            vec_cnt++;
            if (pulses[0] !== 18 || pulses[1] !== 37 || pulses[2] !== 56) begin
                err_cnt++;
                $display("FAIL b2b_spacing got %0d,%0d,%0d want 18,37,56", pulses[0], pulses[1], pulses[2]);
            end
        end
        repeat (25) @(negedge clk_in);
    endtask

    task automatic test_async_reset();
        logic [15:0] p;
        logic        ovf;
        int          lat;
        bit          spurious;
        @(negedge clk_in);
        bus.A = 16'h2000;
        bus.B = 16'h2000;
        bus.in_valid = 1'b1;
        @(posedge clk_in);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk_in);
        #3;
        vec_cnt++;
        if (bus.busy !== 1'b1) begin err_cnt++; $display("FAIL arst_pre_busy got %b want 1", bus.busy); end
        rst_in = 1'b1;
        #1;
        vec_cnt++;
        if ({bus.in_ready, bus.out_valid, bus.P, bus.overflow, bus.busy} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            err_cnt++;
            $display("FAIL arst_outputs got ir=%b ov=%b P=%h ovf=%b busy=%b want ir=1 ov=0 P=0000 ovf=0 busy=0",
                     bus.in_ready, bus.out_valid, bus.P, bus.overflow, bus.busy);
        end
        @(negedge clk_in);
        rst_in = 1'b0;
        spurious = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk_in);
            #1;
            if (bus.out_valid || bus.busy) spurious = 1'b1;
        end
        vec_cnt++;
        if (spurious !== 1'b0) begin err_cnt++; $display("FAIL arst_aborted_result got %b want 0", spurious); end
        do_op(16'h4000, 16'h4000, 1'b1, p, ovf, lat);
        vec_cnt++;
        if (p !== 16'h4000) begin err_cnt++; $display("FAIL arst_new_P got %h want 4000", p); end
        vec_cnt++;
        if (ovf !== 1'b0) begin err_cnt++; $display("FAIL arst_new_overflow got %b want 0", ovf); end
        vec_cnt++;
        if (lat !== 17) begin err_cnt++; $display("FAIL arst_new_latency got %0d want 17", lat); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A = '0;
        bus.B = '0;
        test_reset();
        test_basic();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/fixed_point_mult_seq.md
Name: fixed_point_mult_seq

Overview:
- Multi-cycle signed fixed-point multiplier; the inverse-operation companion to the team's fixed-point divider.
- Computes P = A*B in configurable Q formats using a radix-2 shift-add datapath with rounding and saturation.
- Uses valid/ready handshakes on both input and output, so it can sit in the projection/rasterisation pipelines where a full-width combinational multiplier would break timing or use too many DSPs.

Parameters:
- A_WIDTH, 16, total bits of multiplicand A (signed two's complement)
- A_FRAC_BITS, 14, fractional bits of A
- B_WIDTH, 16, total bits of multiplier B; also the number of iteration cycles
- B_FRAC_BITS, 14, fractional bits of B
- P_WIDTH, 16, total bits of product P
- P_FRAC_BITS, 14, fractional bits of P; must satisfy 1 <= A_FRAC_BITS+B_FRAC_BITS-P_FRAC_BITS (elaboration error otherwise)

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-high
- in_valid  input  1  operands A/B valid
- in_ready  output  1  block can accept operands
- A  input  A_WIDTH  signed multiplicand
- B  input  B_WIDTH  signed multiplier
- out_valid  output  1  P/overflow valid
- out_ready  input  1  consumer accepts result
- P  output  P_WIDTH  signed product, rounded and saturated
- overflow  output  1  result was saturated
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: the block has one clock and an asynchronous active-high reset. Reset values: state=IDLE, in_ready=1, out_valid=0, P=0, overflow=0, busy=0.
- Reset asserted mid-operation aborts immediately; no result is produced for the aborted operation.
- FSM states: IDLE, CALC, FINISH, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch |A| and |B| as unsigned values, sign = A[msb]^B[msb], clear the accumulator and counter, go to CALC.
  - Magnitude of the most negative value (e.g. -32768) is representable, since magnitudes are held in full width.
- CALC:
  - Exactly B_WIDTH cycles.
  - Each cycle: if the current LSB of |B| is 1, add |A| shifted by the counter into the (A_WIDTH+B_WIDTH)-bit unsigned accumulator; shift |B| right; increment the counter.
  - After the cycle with counter==B_WIDTH-1, go to FINISH.
- FINISH (1 cycle):
  - S = A_FRAC_BITS+B_FRAC_BITS-P_FRAC_BITS.
  - mag_r = (acc + 2^(S-1)) >> S, i.e. round half away from zero, applied on the magnitude.
  - Positive result: if mag_r > 2^(P_WIDTH-1)-1, then P = max and overflow=1.
  - Negative result: if mag_r > 2^(P_WIDTH-1), then P = min and overflow=1; otherwise P = -mag_r.
  - A negative result that rounds to magnitude 0 gives P=0 (never -0).
  - Register P and overflow, set out_valid=1, go to DONE.
- DONE:
  - out_valid=1; P and overflow are held stable.
  - On out_ready: clear out_valid, go to IDLE.
  - in_ready returns high on the following cycle.
- Latency:
  - Operands accepted at rising edge t; out_valid is high after edge t+B_WIDTH+1 (17 cycles at default parameters).
  - Minimum initiation interval is B_WIDTH+3 cycles.
- Handshake rules:
  - in_ready is high only in IDLE.
  - A and B are ignored outside the accepting cycle.
  - out_valid never drops without out_ready.
  - out_ready while out_valid=0 has no effect.
  - in_valid held high through the whole operation does not start a second operation until the block is back in IDLE.

Test Plan:
- Defaults (Q2.14), A=8192 (0.5), B=8192 -> P=4096, overflow=0; out_valid rises exactly 17 cycles after the accepting edge.
- A=-24576 (-1.5), B=20480 (1.25) -> P=-30720; A=-32768, B=16384 -> P=-32768, overflow=0.
- Saturation and sign edge cases:
  - A=24576, B=24576 (2.25) -> P=32767, overflow=1.
  - A=-32768, B=-32768 (+4) -> P=32767, overflow=1.
  - A=-32768, B=24576 (-3) -> P=-32768, overflow=1.
- Rounding:
  - A=1, B=8192 (2^-15) -> P=1.
  - A=-1, B=8192 -> P=-1.
  - A=1, B=1 -> P=0.
  - A=-1, B=1 -> P=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> P, overflow and out_valid stable and in_ready=0 throughout; then pulse out_ready -> out_valid=0 and in_ready=1 on the next cycle.
- Assert rst_in asynchronously at CALC cycle 5 -> all outputs at reset values immediately; a new operation (A=16384, B=16384) then completes normally with P=16384.
